// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-side PC owner, imem requester and IF/ID register writer
// Single outstanding fetch; a stalled response parks in a one-entry skid slot.
module fetch_ctrl #(
    parameter int                     ADDR_WIDTH  = 16,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [ADDR_WIDTH-1:0]  PC_STEP     = ADDR_WIDTH'(1),
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic                   if_id_valid_o,
    output logic [INSTR_WIDTH-1:0] if_id_instr_o,
    output logic [ADDR_WIDTH-1:0]  if_id_pc_o
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   squash_q, squash_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_WIDTH-1:0]  skid_pc_q, skid_pc_d;
    logic                   if_valid_q, if_valid_d;
    logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
    logic [ADDR_WIDTH-1:0]  if_pc_q, if_pc_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            squash_q     <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= NOP_INSTR;
            if_pc_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            squash_q     <= squash_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        squash_d     = squash_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;

        // IF/ID bubbles unless stalled; a load below overrides the bubble
        if (flush_i || !stall_i) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end

        case (state_q)
            S_REQ: begin
                if (flush_i) begin
                    pc_d = redirect_pc_i;
                    if (imem_gnt_i) begin
                        state_d  = S_WAIT;
                        squash_d = 1'b1;
                    end
                end else if (imem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                    if (squash_q) begin
                        squash_d = 1'b0;
                        if (flush_i) pc_d = redirect_pc_i;
                    end else if (flush_i) begin
                        pc_d = redirect_pc_i;
                    end else if (!stall_i) begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata_i;
                        if_pc_d    = pc_q;
                        pc_d       = pc_q + PC_STEP;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata_i;
                        skid_pc_d    = pc_q;
                        pc_d         = pc_q + PC_STEP;
                        state_d      = S_HOLD;
                    end
                end else if (flush_i) begin
                    squash_d = 1'b1;
                    pc_d     = redirect_pc_i;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    skid_valid_d = 1'b0;
                    pc_d         = redirect_pc_i;
                    state_d      = S_REQ;
                end else if (!stall_i) begin
                    if_valid_d   = skid_valid_q;
                    if_instr_d   = skid_instr_q;
                    if_pc_d      = skid_pc_q;
                    skid_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign imem_req_o    = (state_q == S_REQ) && !rst_i;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign if_id_valid_o = if_valid_q;
    assign if_id_instr_o = if_instr_q;
    assign if_id_pc_o    = if_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] pc;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;

    int vectors = 0;
    int errors  = 0;

    fetch_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .flush_i       (flush),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .pc_o          (pc),
        .if_id_valid_o (if_id_valid),
        .if_id_instr_o (if_id_instr),
        .if_id_pc_o    (if_id_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        vectors++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h expected 0000", pc); end
        vectors++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", if_id_valid); end
        vectors++; if (if_id_instr !== 16'h0000) begin errors++; $display("FAIL rst_instr: got %h expected 0000", if_id_instr); end
        vectors++; if (if_id_pc !== 16'h0000) begin errors++; $display("FAIL rst_ifpc: got %h expected 0000", if_id_pc); end
        rst = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
        vectors++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL first_addr: got %h expected 0000", imem_addr); end
    endtask

    task automatic test_zero_wait();
        for (int k = 0; k < 4; k++) begin
            vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zw_req[%0d]: got %b expected 1", k, imem_req); end
            vectors++; if (imem_addr !== 16'(k)) begin errors++; $display("FAIL zw_addr[%0d]: got %h expected %h", k, imem_addr, 16'(k)); end
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0;
            vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_wait_req[%0d]: got %b expected 0", k, imem_req); end
            vectors++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL zw_bubble[%0d]: got %b expected 0", k, if_id_valid); end
            imem_rvalid = 1'b1;
            imem_rdata  = 16'h1000 + 16'(k);
            tick();
            imem_rvalid = 1'b0;
            vectors++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d]: got %b expected 1", k, if_id_valid); end
            vectors++; if (if_id_pc !== 16'(k)) begin errors++; $display("FAIL zw_ifpc[%0d]: got %h expected %h", k, if_id_pc, 16'(k)); end
            vectors++; if (if_id_instr !== 16'h1000 + 16'(k)) begin errors++; $display("FAIL zw_instr[%0d]: got %h expected %h", k, if_id_instr, 16'h1000 + 16'(k)); end
            vectors++; if (pc !== 16'(k + 1)) begin errors++; $display("FAIL zw_pc[%0d]: got %h expected %h", k, pc, 16'(k + 1)); end
        end
    endtask

    task automatic test_stall();
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        stall       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hA5A5;
        tick();
        imem_rvalid = 1'b0;
        for (int s = 0; s < 2; s++) begin
            vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 0", s, imem_req); end
            vectors++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 0", s, if_id_valid); end
            vectors++; if (if_id_pc !== 16'h0003) begin errors++; $display("FAIL stall_ifpc[%0d]: got %h expected 0003", s, if_id_pc); end
            if (s == 1) stall = 1'b0;
            tick();
        end
        vectors++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL rel_valid: got %b expected 1", if_id_valid); end
        vectors++; if (if_id_instr !== 16'hA5A5) begin errors++; $display("FAIL rel_instr: got %h expected a5a5", if_id_instr); end
        vectors++; if (if_id_pc !== 16'h0004) begin errors++; $display("FAIL rel_ifpc: got %h expected 0004", if_id_pc); end
        vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req: got %b expected 1", imem_req); end
        vectors++; if (imem_addr !== 16'h0005) begin errors++; $display("FAIL rel_addr: got %h expected 0005", imem_addr); end
    endtask

    task automatic test_flush_wait();
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        flush       = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        flush = 1'b0;
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fw_req: got %b expected 0", imem_req); end
        vectors++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL fw_addr: got %h expected 0040", imem_addr); end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL fw_drop_valid: got %b expected 0", if_id_valid); end
        vectors++; if (if_id_instr !== 16'h0000) begin errors++; $display("FAIL fw_drop_instr: got %h expected 0000", if_id_instr); end
        vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fw_newreq: got %b expected 1", imem_req); end
        vectors++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL fw_newaddr: got %h expected 0040", imem_addr); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'h1234;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (if_id_valid !== 1'b1 || if_id_instr !== 16'h1234 || if_id_pc !== 16'h0040) begin
            errors++; $display("FAIL fw_refetch: got %b/%h/%h expected 1/1234/0040", if_id_valid, if_id_instr, if_id_pc);
        end
    endtask

    task automatic test_flush_gnt();
        flush       = 1'b1;
        redirect_pc = 16'h0010;
        imem_gnt    = 1'b1;
        tick();
        flush    = 1'b0;
        imem_gnt = 1'b0;
        vectors++; if (imem_req !== 1'b0 || imem_addr !== 16'h0010) begin
            errors++; $display("FAIL fg_wait: got req %b addr %h expected 0/0010", imem_req, imem_addr);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hBAD1;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000) begin
            errors++; $display("FAIL fg_drop: got %b/%h expected 0/0000", if_id_valid, if_id_instr);
        end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
            errors++; $display("FAIL fg_newreq: got req %b addr %h expected 1/0010", imem_req, imem_addr);
        end
    endtask

    task automatic test_flush_hold();
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        stall       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'h7777;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (imem_req !== 1'b0 || pc !== 16'h0011) begin
            errors++; $display("FAIL fh_hold: got req %b pc %h expected 0/0011", imem_req, pc);
        end
        flush       = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        vectors++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000 || if_id_pc !== 16'h0040) begin
            errors++; $display("FAIL fh_bubble: got %b/%h/%h expected 0/0000/0040", if_id_valid, if_id_instr, if_id_pc);
        end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0020) begin
            errors++; $display("FAIL fh_req: got req %b addr %h expected 1/0020", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'h2020;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (if_id_valid !== 1'b1 || if_id_instr !== 16'h2020 || if_id_pc !== 16'h0020) begin
            errors++; $display("FAIL fh_after: got %b/%h/%h expected 1/2020/0020", if_id_valid, if_id_instr, if_id_pc);
        end
    endtask

    task automatic test_reset_mid_wait();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_rstreq: got %b expected 0", imem_req); end
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hEEEE;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (if_id_valid !== 1'b0 || if_id_pc !== 16'h0000) begin
            errors++; $display("FAIL rw_ifid: got %b/%h expected 0/0000", if_id_valid, if_id_pc);
        end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL rw_req: got req %b addr %h expected 1/0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        flush       = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        flush = 1'b0;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin
            errors++; $display("FAIL wr_req: got req %b addr %h expected 1/ffff", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'h5A5A;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (if_id_pc !== 16'hFFFF || if_id_instr !== 16'h5A5A) begin
            errors++; $display("FAIL wr_ifid: got %h/%h expected ffff/5a5a", if_id_pc, if_id_instr);
        end
        vectors++; if (pc !== 16'h0000) begin errors++; $display("FAIL wr_pc: got %h expected 0000", pc); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_flush_wait();
        test_flush_gnt();
        test_flush_hold();
        test_reset_mid_wait();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
